// File: rtl/image_pkg.sv
// Shared types and helpers for the image selection path.
// Holds FSM/request encodings, default sizing and the wrap-around index step.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SWAP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        NEXT = 2'd1,
        PREV = 2'd2
    } req_t;

    localparam int DEF_NUM_IMAGES = 4;
    localparam int DEF_IDX_W      = 2;

    // Step an index one position in the requested direction, wrapping at both ends.
    function automatic int unsigned wrap_step(input int unsigned idx,
                                              input req_t        req,
                                              input int unsigned num);
        case (req)
            NEXT:    return (idx == num - 32'd1) ? 32'd0 : idx + 32'd1;
            PREV:    return (idx == 32'd0) ? num - 32'd1 : idx - 32'd1;
            default: return idx;
        endcase
    endfunction

endpackage

// File: rtl/slide_timer.sv
// Auto-advance frame counter: counts frame_start while enabled, pulses expire on the last frame.
// expire is combinational in the expiring frame_start cycle; clear wins over both count and expiry.
module slide_timer #(
    parameter int AUTO_FRAMES = 120,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic frame_start,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(AUTO_FRAMES - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = enable && frame_start && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (enable && frame_start) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/image_sequencer.sv
// Image selection FSM: turns next/prev/auto events into loader requests and tear-free display swaps.
// Pulse to load_req is 1 cycle; load_req/load_index hold until load_ready, one request is queued while busy.
module image_sequencer
    import image_pkg::*;
#(
    parameter int NUM_IMAGES  = DEF_NUM_IMAGES,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int AUTO_FRAMES = 120,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             next_pulse,
    input  logic             prev_pulse,
    input  logic             auto_toggle,
    input  logic             frame_start,
    input  logic             load_ready,
    output logic             load_req,
    output logic [IDX_W-1:0] load_index,
    output logic [IDX_W-1:0] display_index,
    output logic             auto_mode,
    output logic             busy
);

    state_t state;
    req_t   pending;
    req_t   manual_req;
    req_t   req;
    req_t   pend_next;
    logic   timer_expire;

    slide_timer #(
        .AUTO_FRAMES (AUTO_FRAMES),
        .CNT_W       (CNT_W)
    ) u_slide_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (auto_mode && (state == IDLE)),
        .clear       (auto_toggle || next_pulse || prev_pulse),
        .frame_start (frame_start),
        .expire      (timer_expire)
    );

    // Opposing manual pulses cancel; any manual pulse shadows a timer expiry.
    always_comb begin
        manual_req = NONE;
        if (next_pulse && !prev_pulse) begin
            manual_req = NEXT;
        end else if (prev_pulse && !next_pulse) begin
            manual_req = PREV;
        end
        req = manual_req;
        if (manual_req == NONE && timer_expire) begin
            req = NEXT;
        end
        pend_next = (req != NONE) ? req : pending;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= NONE;
            load_req      <= 1'b0;
            load_index    <= '0;
            display_index <= '0;
            auto_mode     <= 1'b0;
        end else begin
            if (auto_toggle) begin
                auto_mode <= !auto_mode;
            end
            case (state)
                IDLE: begin
                    if (req != NONE) begin
                        load_index <= IDX_W'(wrap_step(32'(display_index), req, NUM_IMAGES));
                        load_req   <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    pending <= pend_next;
                    if (load_ready) begin
                        load_req <= 1'b0;
                        state    <= SWAP;
                    end
                end
                SWAP: begin
                    if (frame_start) begin
                        display_index <= load_index;
                        // A queued request chains straight into the next load, based on the new image.
                        if (pend_next != NONE) begin
                            load_index <= IDX_W'(wrap_step(32'(load_index), pend_next, NUM_IMAGES));
                            load_req   <= 1'b1;
                            pending    <= NONE;
                            state      <= LOAD;
                        end else begin
                            pending <= NONE;
                            state   <= IDLE;
                        end
                    end else begin
                        pending <= pend_next;
                    end
                end
                default: begin
                    state    <= IDLE;
                    load_req <= 1'b0;
                    pending  <= NONE;
                end
            endcase
        end
    end

endmodule
